// File: rtl/vga_apb_pkg.sv
// Shared definitions for the VGA configuration APB requester.
// Holds the FSM encoding, config register map and default timeout.
package vga_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic [1:0] REG_BASE     = 2'd0;
    localparam logic [1:0] REG_OFFSET   = 2'd1;
    localparam logic [1:0] REG_SELFTEST = 2'd2;
    localparam logic [1:0] REG_RESSEL   = 2'd3;

    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/apb_watchdog.sv
// Saturating ACCESS-phase wait counter with an expiry flag.
// Ports: clk, resetn (sync, active-low), clear, enable -> expired.
module apb_watchdog
    import vga_apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
            localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] count;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable && count != TOP) begin
                    // Hold at the top value instead of wrapping.
                    count <= count + 1'b1;
                end
            end

            assign expired = (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_cfg_master.sv
// APB requester turning one valid/ready command into one APB transfer.
// Ports: cmd_* in, rsp_* out, APB p* bus; clk, resetn (sync, active-low).
module apb_cfg_master
    import vga_apb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    input  logic                  pready_i,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pslverr_i
);

    apb_state_t state;
    apb_state_t state_next;

    logic accept;
    logic done;
    logic abort;
    logic wd_clear;
    logic wd_en;
    logic expired;

    assign cmd_ready_o = resetn && (state == IDLE) && !rsp_valid_o;

    apb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .clear  (wd_clear),
        .enable (wd_en),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        wd_clear   = 1'b0;
        wd_en      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                wd_clear   = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                // pready has priority over an expiry in the same cycle.
                if (pready_i) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    wd_en = 1'b1;
                    if (expired) begin
                        abort      = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            paddr_o       <= '0;
            pwdata_o      <= '0;
            pwrite_o      <= 1'b0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            if (accept) begin
                paddr_o   <= cmd_addr_i;
                pwdata_o  <= cmd_wdata_i;
                pwrite_o  <= cmd_write_i;
                psel_o    <= 1'b1;
                penable_o <= 1'b0;
            end

            if (state == SETUP) begin
                penable_o <= 1'b1;
            end

            if (done) begin
                rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
                rsp_err_o     <= pslverr_i;
                rsp_timeout_o <= 1'b0;
                rsp_valid_o   <= 1'b1;
                psel_o        <= 1'b0;
                penable_o     <= 1'b0;
            end else if (abort) begin
                rsp_rdata_o   <= '0;
                rsp_err_o     <= 1'b1;
                rsp_timeout_o <= 1'b1;
                rsp_valid_o   <= 1'b1;
                psel_o        <= 1'b0;
                penable_o     <= 1'b0;
            end

            if (rsp_valid_o && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

endmodule
